addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, digit-serial adder/subtractor, the multi-cycle successor to the team's fixed 4-bit ripple add/sub. It takes two WIDTH-bit operands through a valid/ready handshake and a mode bit, processes DIGIT bits per clock through one shared ripple slice, and returns the result with carry/borrow and status flags through a second valid/ready handshake. It sits between the ALU operand registers and the result writeback, trading latency for area on wide datapaths.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept operands.
- mode  in  1  0 = add (a+b+cin), 1 = subtract (a−b, computed as a+~b+1; cin ignored).
- cin  in  1  carry-in for add.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  add: carry-out; subtract: 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed two's-complement overflow (see Configuration).
- zero  out  1  result == 0 (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: latch a, b_eff (b, or ~b when mode=1), carry register ← (mode ? 1 : cin), digit counter ← 0; go BUSY.
- BUSY: each cycle add digit[cnt] of a and b_eff with carry register; write DIGIT sum bits into result[cnt*DIGIT +: DIGIT]; carry register ← slice carry-out; cnt++. After digit NDIG−1, go DONE.
- DONE: out_valid=1; result/cout/ovf/zero stable until out_ready. On out_ready: go IDLE.
- Inputs ignored outside IDLE; in_ready=0 in BUSY and DONE.
- ovf = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
- rst_n=0 in any state (including mid-BUSY): next edge → IDLE, partial result discarded.
- Reset values: in_ready=1 (after reset edge), out_valid=0, result=0, cout=0, ovf=0, zero=0.

## Timing
- Accept on edge where in_valid && in_ready.
- Latency: out_valid rises NDIG+1 edges after the accept edge (NDIG BUSY cycles, then DONE).
- DIGIT=WIDTH: single BUSY cycle, latency 2.
- Result held indefinitely under out_ready=0 backpressure.
- Throughput: one operation per NDIG+2 cycles with out_ready held high (IDLE→BUSY×NDIG→DONE→IDLE).
- out_ready asserted in IDLE/BUSY: no effect.
- Carry propagates combinationally within one DIGIT slice only; critical path is DIGIT full-adder stages.

## Configuration
- ADDSUB_FLAGS_EN defined: ovf and zero computed as above, registered on entry to DONE, valid with out_valid.
- Not defined: ovf and zero tied to 0, flag logic absent; result and cout unaffected; port list unchanged.

## Structure
- Shared package addsub_pkg: FSM state enum (IDLE, BUSY, DONE), mode encoding constants (MODE_ADD=0, MODE_SUB=1).
- One sub-module, addsub_digit: DIGIT-bit combinational ripple adder (sum, carry-out, carry-in), built from the team's existing full-adder cell and instantiated once.
- Counter width $clog2(NDIG), minimum 1.

## Test plan
- WIDTH=16, DIGIT=4, add a=0x1234, b=0x0FFF, cin=0 → out_valid 5 edges after accept, result=0x2233, cout=0, ovf=0.
- Subtract a=0x0003, b=0x0005 → result=0xFFFE, cout=0 (borrow); a=0x0005, b=0x0005 → result=0x0000, cout=1, zero=1 (flags build).
- Add a=0x7FFF, b=0x0001 → result=0x8000, ovf=1 with ADDSUB_FLAGS_EN, ovf=0 without; add a=0xFFFF, b=0x0000, cin=1 → result=0x0000, cout=1.
- Hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, new in_valid ignored; then out_ready=1 → IDLE next edge, next operation accepted.
- rst_n=0 during second BUSY cycle → next edge out_valid=0, result=0, in_ready=1; following operation completes correctly.
- DIGIT=1 and DIGIT=16 builds: random add/sub vs. reference model, latency 17 and 2 respectively.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Consumers: addsub_serial (FSM state encoding, mode decode, counter sizing).
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Digit counter width; a single-digit build still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple adder slice built from a chain of full-adder cells.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: one shared DIGIT-bit slice iterated NDIG times per operation.
// Optional macro ADDSUB_FLAGS_EN enables the registered ovf/zero status flags.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic [WIDTH-1:0]   merged_result;
    logic               last_digit;

    assign dig_a = DIGIT'(a_q >> (int'(cnt_q) * DIGIT));
    assign dig_b = DIGIT'(b_q >> (int'(cnt_q) * DIGIT));

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // Current slice output dropped into its digit position, other digits kept.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_merge
            assign merged_result[gi*DIGIT +: DIGIT] =
                (cnt_q == CNT_W'(gi)) ? dig_sum : result_q[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign last_digit = (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = (mode == MODE_SUB) ? ~b : b;
                    carry_d = (mode == MODE_SUB) ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                result_d = merged_result;
                carry_d  = dig_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = carry_q;

`ifdef ADDSUB_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    // Flags are captured from the fully assembled result as the last digit completes.
    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if ((state_q == BUSY) && last_digit) begin
            ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (merged_result[WIDTH-1] != a_q[WIDTH-1]);
            zero_d = (merged_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: directed vectors queue expected results, a monitor checks outputs.
// DIGIT may be overridden (1, 4, 16); ADDSUB_FLAGS_EN selects the flag expectations.
module tb_addsub_serial;

    parameter int DIGIT = 4;
    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / DIGIT;
`ifdef ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mode = 1'b0;
    logic              cin = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  result;
    logic              cout;
    logic              ovf;
    logic              zero;

    addsub_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        logic             z;
        int               acc;
        bit               seen;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q[0];
                if (!mon_e.seen) begin
                    check("latency", cyc - mon_e.acc, NDIG + 1);
                    exp_q[0].seen = 1'b1;
                end
                check("result", result, mon_e.res);
                check("cout", cout, mon_e.co);
                check("ovf", ovf, FLAGS & mon_e.ov);
                check("zero", zero, FLAGS & mon_e.z);
                check("in_ready_in_done", in_ready, 1'b0);
                $display("op done: result=%04h cout=%0d ovf=%0d zero=%0d", result, cout, ovf, zero);
                if (out_ready) exp_q.delete(0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic m, input logic c, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] res,
                        input logic co, input logic ov, input logic z);
        exp_t e;
        @(negedge clk);
        wait_ready();
        mode     = m;
        cin      = c;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        e.res  = res;
        e.co   = co;
        e.ov   = ov;
        e.z    = z;
        e.acc  = cyc;
        e.seen = 1'b0;
        exp_q.push_back(e);
        $display("issue: mode=%0d cin=%0d a=%04h b=%04h expect=%04h", m, c, av, bv, res);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_zero", zero, 1'b0);
        rst_n = 1'b1;

        //   mode cin  a         b         result    co    ov    z
        send(1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0101, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: result must hold while new operands are offered and ignored.
        out_ready = 1'b0;
        send(1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid", out_valid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            mode     = 1'b0;
            a        = 16'hFFFF;
            b        = 16'hFFFF;
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        send(1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b1, 1'b1, 1'b0);
        drain();

        // Reset in the second BUSY cycle discards the partial result.
        out_ready = 1'b0;
        send(1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result, 16'h0000);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_cout", cout, 1'b0);
        exp_q.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
